// File: rtl/conv2_kernel_fetch.sv
// conv2_kernel_fetch
//   Streams one convolution kernel out of a dual-port weight ROM as a sequence
//   of (even, odd) weight pairs. Each read issue puts two adjacent addresses on
//   the ROM ports. The two words come back two edges later and are queued in a
//   4-entry FIFO that drives a valid/ready output stream.
//
// Ports
//   clock        sole clock, all state on posedge
//   reset        synchronous active-high reset
//   start        one-cycle kernel request, honoured only in IDLE
//   kernel_idx   kernel number, latched when start is accepted
//   address_a/b  registered ROM addresses (even / odd word of a pair)
//   q_a/q_b      ROM data, valid one clock after the address is sampled
//   weight_a/b   head-of-FIFO weight pair
//   out_valid    a pair is presented
//   out_ready    consumer accepts the presented pair
//   out_last     presented pair is the final pair of the kernel
//   busy         kernel stream in progress
//   done         one-cycle pulse after the final transfer
module conv2_kernel_fetch #(
  parameter int KLEN  = 16,
  parameter int NKERN = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  kernel_idx,
  output logic [7:0]  address_a,
  output logic [7:0]  address_b,
  input  logic [15:0] q_a,
  input  logic [15:0] q_b,
  output logic [15:0] weight_a,
  output logic [15:0] weight_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam int         NPAIR     = KLEN / 2;
  localparam logic [7:0] LAST_PAIR = 8'(NPAIR - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  base_reg;
  logic [7:0]  pair_reg;
  logic [7:0]  addr_even;

  // Two-stage issue pipeline: stage 1 = address registered, stage 2 = ROM
  // has sampled the address; data is captured on the edge after stage 2.
  logic        s1_valid_reg, s1_last_reg;
  logic        s2_valid_reg, s2_last_reg;

  logic [2:0]  count_reg;
  logic [1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [15:0] mem_a [4];
  logic [15:0] mem_b [4];
  logic        mem_last [4];

  logic        accept, issue, issue_last, push, pop;
  logic [3:0]  occupancy;

  assign accept    = start && ({1'b0, kernel_idx} < 9'(NKERN));
  assign push      = s2_valid_reg;
  assign out_valid = (count_reg != 3'd0);
  assign pop       = out_valid && out_ready;
  assign weight_a  = mem_a[rd_ptr_reg];
  assign weight_b  = mem_b[rd_ptr_reg];
  assign out_last  = mem_last[rd_ptr_reg];

  // Everything already buffered or on its way, minus what leaves this cycle.
  // Keeping this below 4 before issuing guarantees the FIFO cannot overflow.
  assign occupancy  = {1'b0, count_reg} + {3'b0, s1_valid_reg}
                    + {3'b0, s2_valid_reg} - {3'b0, pop};
  assign issue      = (state_reg == FETCH) && (occupancy < 4'd4);
  assign issue_last = issue && (pair_reg == LAST_PAIR);
  assign addr_even  = base_reg + (pair_reg << 1);

  always_ff @(posedge clock) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE:  if (accept) state_next = FETCH;
      FETCH: begin
        busy = 1'b1;
        if (issue_last) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (pop && out_last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      base_reg     <= 8'd0;
      pair_reg     <= 8'd0;
      address_a    <= 8'd0;
      address_b    <= 8'd0;
      s1_valid_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      s2_valid_reg <= 1'b0;
      s2_last_reg  <= 1'b0;
      count_reg    <= 3'd0;
      wr_ptr_reg   <= 2'd0;
      rd_ptr_reg   <= 2'd0;
    end else begin
      if (state_reg == IDLE && accept) begin
        base_reg <= 8'(kernel_idx * KLEN);
        pair_reg <= 8'd0;
      end
      // Addresses only move on an issue, so they hold during a stall.
      if (issue) begin
        address_a <= addr_even;
        address_b <= addr_even + 8'd1;
        pair_reg  <= pair_reg + 8'd1;
      end
      s1_valid_reg <= issue;
      s1_last_reg  <= issue_last;
      s2_valid_reg <= s1_valid_reg;
      s2_last_reg  <= s1_last_reg;
      if (push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 2'd1;
      count_reg <= count_reg + {2'b0, push} - {2'b0, pop};
    end
  end

  // FIFO storage, one register set per entry. Entries are cleared on reset so
  // the head reads as zero afterwards.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fifo
      always_ff @(posedge clock) begin
        if (reset) begin
          mem_a[gi]    <= 16'd0;
          mem_b[gi]    <= 16'd0;
          mem_last[gi] <= 1'b0;
        end else if (push && (wr_ptr_reg == 2'(gi))) begin
          mem_a[gi]    <= q_a;
          mem_b[gi]    <= q_b;
          mem_last[gi] <= s2_last_reg;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_conv2_kernel_fetch.sv
module tb_conv2_kernel_fetch;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  kernel_idx;
  logic [7:0]  address_a, address_b;
  logic [15:0] q_a, q_b;
  logic [15:0] weight_a, weight_b;
  logic        out_valid, out_ready, out_last, busy, done;

  int checks = 0;
  int errors = 0;

  conv2_kernel_fetch #(.KLEN(16), .NKERN(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .kernel_idx (kernel_idx),
    .address_a  (address_a),
    .address_b  (address_b),
    .q_a        (q_a),
    .q_b        (q_b),
    .weight_a   (weight_a),
    .weight_b   (weight_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ROM model with ROM[i] = i and a registered read.
  always @(posedge clock) begin
    q_a <= {8'h00, address_a};
    q_b <= {8'h00, address_b};
  end

  task automatic do_start(input int idx);
    start      = 1'b1;
    kernel_idx = 8'(idx);
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
  endtask

  // Collects one kernel stream. c = 0 is the negedge after the accepting edge.
  // mode 0: ready high; 1: ready 1,0,0,1 repeating; 2: ready low for 20 cycles.
  task automatic collect(input int base, input int mode, input bit inject, input string tag);
    int k = 0;
    int c = 0;
    int first_c = -1;
    bit finished = 0;
    bit prev_hold = 0;
    logic [15:0] held_a, held_b;
    logic held_last;
    held_a = 0; held_b = 0; held_last = 0;
    while (!finished && c < 300) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ((c % 4) == 0) || ((c % 4) == 3);
        default: out_ready = (c >= 20);
      endcase
      if (inject) begin
        start      = (c == 5);
        kernel_idx = 8'd0;
      end
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s busy/done c=%0d got busy=%b done=%b expected busy=1 done=0", tag, c, busy, done);
      end
      if (mode == 2 && c == 19) begin
        checks++;
        if (address_a !== 8'(base + 6) || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL %s stall_addr got addr=%0d valid=%b expected addr=%0d valid=1", tag, address_a, out_valid, base + 6);
        end
      end
      if (prev_hold) begin
        checks++;
        if (weight_a !== held_a || weight_b !== held_b || out_last !== held_last) begin
          errors++;
          $display("FAIL %s hold c=%0d got (%0d,%0d,%b) expected (%0d,%0d,%b)", tag, c, weight_a, weight_b, out_last, held_a, held_b, held_last);
        end
      end
      if (out_valid === 1'b1 && first_c < 0) begin
        first_c = c;
        if (mode != 2) begin
          checks++;
          if (c != 3) begin
            errors++;
            $display("FAIL %s latency got %0d expected 3", tag, c);
          end
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (weight_a !== 16'(base + 2*k) || weight_b !== 16'(base + 2*k + 1) || out_last !== (k == 7)) begin
          errors++;
          $display("FAIL %s pair%0d got (%0d,%0d,last=%b) expected (%0d,%0d,last=%b)", tag, k, weight_a, weight_b, out_last, base + 2*k, base + 2*k + 1, (k == 7));
        end
        if (mode == 0) begin
          checks++;
          if (c != 3 + k) begin
            errors++;
            $display("FAIL %s rate pair%0d got cycle %0d expected %0d", tag, k, c, 3 + k);
          end
        end
        k++;
        if (k == 8) finished = 1;
      end
      prev_hold = (out_valid === 1'b1) && (out_ready === 1'b0);
      held_a = weight_a; held_b = weight_b; held_last = out_last;
      @(negedge clock);
      c++;
    end
    if (inject) start = 1'b0;
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s timeout got %0d pairs expected 8", tag, k);
    end else begin
      $display("%s: 8 pairs from base %0d, first valid at cycle %0d", tag, base, first_c);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s done_pulse got done=%b busy=%b valid=%b expected 1 0 0", tag, done, busy, out_valid);
      end
      @(negedge clock);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s done_clear got done=%b busy=%b expected 0 0", tag, done, busy);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (address_a !== 8'd0 || address_b !== 8'd0 || weight_a !== 16'd0 || weight_b !== 16'd0 ||
        out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s reset_values got a=%0d b=%0d wa=%0d wb=%0d v=%b l=%b busy=%b done=%b expected all 0",
               tag, address_a, address_b, weight_a, weight_b, out_valid, out_last, busy, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_reset_values("reset");
    @(negedge clock);
    check_reset_values("reset_idle");
    $display("test_reset: done");
  endtask

  task automatic test_full_rate();
    do_start(2);
    collect(32, 0, 0, "full_rate");
  endtask

  task automatic test_back_pressure();
    do_start(2);
    collect(32, 1, 0, "back_pressure");
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    do_start(2);
    collect(32, 2, 0, "stall");
  endtask

  task automatic test_ignored_starts();
    out_ready = 1'b1;
    do_start(16);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL ignore_idx16 cycle %0d got busy=%b done=%b valid=%b expected 0 0 0", i, busy, done, out_valid);
      end
      @(negedge clock);
    end
    $display("ignore_idx16: no activity");
    do_start(2);
    collect(32, 0, 1, "ignore_busy_start");
  endtask

  task automatic test_reset_mid_stream();
    int transfers = 0;
    int guard = 0;
    out_ready = 1'b1;
    do_start(2);
    while (transfers < 3 && guard < 50) begin
      if (out_valid === 1'b1) transfers++;
      @(negedge clock);
      guard++;
    end
    checks++;
    if (transfers != 3) begin
      errors++;
      $display("FAIL reset_mid transfers got %0d expected 3", transfers);
    end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_reset_values("reset_mid");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_quiet cycle %0d got valid=%b done=%b busy=%b expected 0 0 0", i, out_valid, done, busy);
      end
    end
    $display("reset_mid: outputs cleared after 3 transfers");
    do_start(0);
    collect(0, 0, 0, "restart_k0");
  endtask

  task automatic test_last_kernel();
    do_start(15);
    collect(240, 0, 0, "last_kernel");
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    kernel_idx = 8'd0;
    out_ready  = 1'b0;
    test_reset();
    test_full_rate();
    test_back_pressure();
    test_stall();
    test_ignored_starts();
    test_reset_mid_stream();
    test_last_kernel();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv2_kernel_fetch.md
CONV2_KERNEL_FETCH -- requirements
Module: conv2_kernel_fetch

Interface
REQ-001 Parameter KLEN, default 16: 16-bit weight words per kernel; SHALL be even, 2..256.
REQ-002 Parameter NKERN, default 16: kernels held in the ROM; KLEN*NKERN SHALL be <= 256.
REQ-003 clock  input  1  sole clock; all state updates on posedge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to stream one kernel; sampled only in IDLE.
REQ-006 kernel_idx  input  8  kernel number; latched when start is accepted.
REQ-007 address_a  output  8  ROM port-A address; registered.
REQ-008 address_b  output  8  ROM port-B address; registered.
REQ-009 q_a  input  16  ROM port-A data; valid one clock after the ROM samples address_a.
REQ-010 q_b  input  16  ROM port-B data; valid one clock after the ROM samples address_b.
REQ-011 weight_a  output  16  even-offset weight of the current pair (FIFO head).
REQ-012 weight_b  output  16  odd-offset weight of the current pair (FIFO head).
REQ-013 out_valid  output  1  weight pair presented.
REQ-014 out_ready  input  1  consumer accepts; a pair transfers when out_valid && out_ready.
REQ-015 out_last  output  1  presented pair is the final pair of the kernel.
REQ-016 busy  output  1  high from start acceptance until done pulses.
REQ-017 done  output  1  one-cycle pulse after the final transfer.

Function
REQ-018 States: IDLE, FETCH, DRAIN, DONE.
REQ-019 IDLE -> FETCH on start: latch base = kernel_idx*KLEN (8-bit), clear pair counter, set busy.
REQ-020 kernel_idx >= NKERN: start is ignored; block stays in IDLE; busy and done stay 0.
REQ-021 start in any state other than IDLE is ignored.
REQ-022 Read issue i (i = 0..KLEN/2-1): address_a = base+2i, address_b = base+2i+1.
REQ-023 Issue i SHALL register its addresses on one edge; q_a/q_b for that issue SHALL be captured into the output FIFO two edges later.
REQ-024 Output FIFO: 4 entries, each {q_a, q_b, last flag}; the head drives weight_a, weight_b and out_last.
REQ-025 Issue rule: a read issues only if fifo_count + inflight - pop_this_cycle < 4, where inflight (0..2) counts issued pairs not yet captured; the FIFO SHALL never overflow.
REQ-026 Full rate: with out_ready held high, one pair transfers per cycle with no bubbles after the first.
REQ-027 Latency: start accepted at edge N -> out_valid first high after edge N+3.
REQ-028 out_ready low: issue stalls per REQ-025; data already in flight is captured, not dropped; address_a/b hold their last value.
REQ-029 FETCH -> DRAIN when the last pair has issued; DRAIN -> DONE on transfer of the pair with out_last.
REQ-030 DONE: done = 1 for exactly one cycle, busy = 0 in the same cycle; next state is IDLE.
REQ-031 Order: pairs are delivered strictly in address order; out_last is high only on pair KLEN/2-1.
REQ-032 weight_a/weight_b/out_last are don't-care when out_valid = 0 but SHALL hold stable while out_valid && !out_ready.
REQ-033 Address arithmetic is 8-bit and never wraps under legal parameters (REQ-002).

Reset
REQ-034 Reset SHALL force IDLE and clear the FIFO, inflight count, pair counter and base.
REQ-035 Reset values: address_a = 0, address_b = 0, weight_a = 0, weight_b = 0, out_valid = 0, out_last = 0, busy = 0, done = 0.
REQ-036 Reset mid-stream: in-flight ROM data arriving after reset SHALL be discarded, and no done pulse is produced.

Verification
REQ-037 KLEN=16, ROM[i]=i, start with kernel_idx=2, out_ready=1 -> 8 pairs (32,33)..(46,47) on consecutive cycles; first after edge N+3; out_last on (46,47); done one cycle after.
REQ-038 Same setup, out_ready toggled 1,0,0,1 repeating -> identical 8-pair sequence; no loss or duplication; FIFO count never exceeds 4.
REQ-039 out_ready=0 for 20 cycles after start -> address issue stops after 4 pairs are buffered or in flight; release -> remaining pairs follow in order.
REQ-040 start pulsed while busy, and start with kernel_idx=16 -> both ignored; no change to the stream in progress; no busy in the idle case.
REQ-041 reset asserted after 3 transfers -> next cycle all outputs at reset values; a fresh start with kernel_idx=0 yields (0,1) first.
REQ-042 kernel_idx=15 (last kernel) -> final pair (254,255) with out_last=1; addresses never exceed 255.
